soc_irq_ctrl: RTL
=================

// Module: soc_irq_ctrl
// PURPOSE
//  Interrupt controller directly downstream of the SoC interval timer and the other
//  Avalon-MM peripherals. Collects up to 16 per-peripheral irq lines and latches
//  them as pending in edge or level mode. Masks them, resolves the fixed-priority
//  winner and drives one registered irq plus a vector id to the CPU.
//  Software accesses it through a 16-bit Avalon-MM slave with the same register
//  style as the timer.
// PARAMETERS
//  NUM_IRQ   8  number of irq inputs, legal range 1..16; bit 0 is the highest priority
//  SYNC_EN   0  0: irq_in is sampled through 1 flop; 1: 2-flop synchroniser (async sources)
// PORTS
//  clk         in   1        single clock; every flop is on its rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  chipselect  in   1        Avalon-MM slave select
//  address     in   3        register word address
//  write_n     in   1        active-low write strobe
//  writedata   in   16       write data
//  readdata    out  16       registered read data
//  irq_in      in   NUM_IRQ  peripheral irq lines, active-high (timer irq on bit 0)
//  irq_out     out  1        registered CPU interrupt request
//  irq_id      out  4        index of the highest-priority masked pending source
// BEHAVIOUR
//  Reset: readdata, irq_out, irq_id, pending, mask, edge and sample flops are all 0.
//  Sampling:
//   - irq_s = irq_in delayed by 1 flop (SYNC_EN=0) or 2 flops (SYNC_EN=1).
//   - irq_d = irq_s delayed by one more cycle.
//  Pending, bit i:
//   - level mode (edge[i]=0): pending[i] = irq_s[i]. W1C and FORCE have no effect.
//   - edge mode (edge[i]=1): set when irq_s[i] & ~irq_d[i], or by FORCE write 1.
//     Cleared by a PENDING write 1. Set and clear in the same cycle: set wins.
//   - Changing edge[i] from 1 to 0 clears the edge-latched pending[i].
//  Output:
//   - act = pending & mask.
//   - irq_out <= |act and irq_id <= lowest set index of act, both registered.
//   - irq_id holds its last value when act == 0.
//  Latency, SYNC_EN=0, edge mode: irq_in high before edge N.
//   - irq_s high after edge N.
//   - pending high after edge N+1.
//   - irq_out high after edge N+2.
//   - SYNC_EN=1 adds 1 cycle.
//  Register map, 16-bit. Bits at or above NUM_IRQ read 0 and ignore writes.
//   0 RAW      RO   irq_s
//   1 PENDING  R/W1C  pending
//   2 MASK     RW   enable mask
//   3 EDGE     RW   1 = edge capture, 0 = level
//   4 ACTIVE   RO   {valid[15], 11'b0, id[3:0]}; valid = |act
//   5 FORCE    WO   write 1 sets pending on edge-mode bits; reads 0
//   6,7            reads 0, writes ignored
//  Bus timing:
//   - write = chipselect & ~write_n, takes effect at the next edge.
//   - readdata is registered from the address every cycle, independent of chipselect,
//     so it is valid 1 cycle after the address.
//   - A read in the cycle after a write returns the updated value.
//  Reset asserted mid-operation clears all state immediately; irq_out drops without
//  waiting for a clock edge.
// STRUCTURE
//  Package soc_irq_pkg:
//   - address constants ADDR_RAW..ADDR_FORCE
//   - IRQ_MAX = 16
//   - ACTIVE_VALID_BIT = 15
//  Sub-module soc_irq_prio_enc (combinational, NUM_IRQ-wide):
//   - outputs {valid, id}
//   - instantiated once for act; the ACTIVE read path and irq_id share it
// TESTING
//  1. Timer tick: NUM_IRQ=8, EDGE=0x01, MASK=0x01, pulse irq_in[0] for 1 cycle
//     -> irq_out=1 two edges after the sample, irq_id=0.
//     -> write PENDING=0x0001 -> irq_out=0 one cycle after pending clears.
//  2. Priority: edge mode on all bits, MASK=0xFF, irq_in=0x28
//     -> irq_id=3, ACTIVE=0x8003.
//     -> W1C 0x08 -> irq_id=5.
//     -> W1C 0x20 -> irq_out=0, ACTIVE=0x0000.
//  3. Set/clear collision: W1C bit 2 in the same cycle as a new edge on irq_in[2]
//     -> pending[2] stays 1.
//  4. Level mode with MASK=0x10: hold irq_in[4] high
//     -> W1C 0x10 has no effect; deassert -> irq_out=0 two cycles later.
//     -> MASK=0 while asserted -> irq_out=0 next cycle, PENDING still reads 0x0010.
//  5. Force plus reset: FORCE=0x80 with EDGE=0x80, MASK=0x80 -> irq_id=7, irq_out=1.
//     -> assert reset_n=0 mid-cycle -> irq_out, readdata and all registers read 0.
//  6. Bounds: NUM_IRQ=3, write MASK=0xFFFF -> MASK reads 0x0007.
//     -> address 6 and 7 read 0x0000.

Source files
------------

// File: rtl/soc_irq_pkg.sv
// Shared constants for the interrupt controller: register word addresses and
// field positions used by both the RTL and its bus interface.
package soc_irq_pkg;
  localparam int IRQ_MAX          = 16;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;
endpackage

// File: rtl/soc_irq_ctrl_if.sv
// 16-bit Avalon-MM slave bus of the interrupt controller.
interface soc_irq_ctrl_if;
  import soc_irq_pkg::*;

  // Zero-wait-state slave, no ready: a write (chipselect & ~write_n) lands at the
  // next rising edge; readdata is registered from address every cycle.
  logic               chipselect;
  logic [2:0]         address;
  logic               write_n;
  logic [IRQ_MAX-1:0] writedata;
  logic [IRQ_MAX-1:0] readdata;

  modport master (output chipselect, address, write_n, writedata, input readdata);
  modport slave  (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; id is 0 when nothing is requesting.
module soc_irq_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [3:0]   id
);
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end
endmodule

// File: rtl/soc_irq_ctrl.sv
// Interrupt controller: samples peripheral irq lines, latches pending in edge or
// level mode, masks them and drives a registered irq plus winning vector id.
module soc_irq_ctrl
  import soc_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter bit SYNC_EN = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  soc_irq_ctrl_if.slave      bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [3:0]         irq_id
);
  logic [NUM_IRQ-1:0] irq_s, irq_d;
  logic [NUM_IRQ-1:0] pending, mask, edge_mode;
  logic [NUM_IRQ-1:0] wdata, rise, w1c, frc, pend_next, act;
  logic               wr, act_valid;
  logic [3:0]         act_id;
  logic [IRQ_MAX-1:0] raw16, pend16, mask16, edge16, active16, rdata_next;

  generate
    if (SYNC_EN) begin : g_sync
      logic [NUM_IRQ-1:0] meta;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta  <= '0;
          irq_s <= '0;
        end else begin
          meta  <= irq_in;
          irq_s <= meta;
        end
      end
    end else begin : g_nosync
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_s <= '0;
        else          irq_s <= irq_in;
      end
    end
  endgenerate

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[NUM_IRQ-1:0];
  assign rise  = irq_s & ~irq_d;
  assign w1c   = (wr && (bus.address == ADDR_PENDING)) ? wdata : '0;
  assign frc   = (wr && (bus.address == ADDR_FORCE))   ? wdata : '0;

  // Edge bits: set (edge or force) beats W1C. Level bits simply track irq_s, which
  // also discards any edge-latched state once a bit is switched back to level.
  assign pend_next = (edge_mode & ((pending & ~w1c) | rise | frc)) |
                     (~edge_mode & irq_s);
  assign act       = pending & mask;

  soc_irq_prio_enc #(.W(NUM_IRQ)) u_prio (
    .req   (act),
    .valid (act_valid),
    .id    (act_id)
  );

  always_comb begin
    raw16    = '0;
    pend16   = '0;
    mask16   = '0;
    edge16   = '0;
    active16 = '0;
    raw16[NUM_IRQ-1:0]         = irq_s;
    pend16[NUM_IRQ-1:0]        = pending;
    mask16[NUM_IRQ-1:0]        = mask;
    edge16[NUM_IRQ-1:0]        = edge_mode;
    active16[ACTIVE_VALID_BIT] = act_valid;
    active16[3:0]              = act_id;
    case (bus.address)
      ADDR_RAW:     rdata_next = raw16;
      ADDR_PENDING: rdata_next = pend16;
      ADDR_MASK:    rdata_next = mask16;
      ADDR_EDGE:    rdata_next = edge16;
      ADDR_ACTIVE:  rdata_next = active16;
      default:      rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_d        <= '0;
      pending      <= '0;
      mask         <= '0;
      edge_mode    <= '0;
      irq_out      <= 1'b0;
      irq_id       <= '0;
      bus.readdata <= '0;
    end else begin
      irq_d        <= irq_s;
      pending      <= pend_next;
      irq_out      <= act_valid;
      bus.readdata <= rdata_next;
      if (act_valid) irq_id <= act_id;
      if (wr && (bus.address == ADDR_MASK)) mask <= wdata;
      if (wr && (bus.address == ADDR_EDGE)) edge_mode <= wdata;
    end
  end
endmodule
